drum_step_sequencer: RTL and testbench
======================================

Name: drum_step_sequencer

Overview:
- Trigger-side initiator for the ADSR volume shaper.
- Steps through a 16-entry drum pattern at a programmable tempo.
- On each "hit" step, issues a one-cycle start pulse plus the 8-bit ADSR parameter set selected by that step.
- Monitors the shaper's idle flag so that non-retriggerable voices skip hits while an envelope is still sounding.

Parameters:
- NUM_STEPS, 16, pattern length; power of two; index wraps NUM_STEPS-1 -> 0.
- PERIOD_W, 24, width of the step period counter.
- RETRIG, 1, 1: hits always fire (the shaper restarts); 0: a hit is skipped when adsr_idle=0.

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous, active-high.
- run  in  1  level; 1 = sequencer running, 0 = stopped.
- step_period  in  PERIOD_W  clock cycles per step; sampled at each step boundary.
- wr_en  in  1  pattern write strobe.
- wr_addr  in  log2(NUM_STEPS)  pattern entry address.
- wr_data  in  3  entry {hit, preset[1:0]}.
- adsr_idle  in  1  idle flag from the volume shaper.
- start  out  1  one-cycle trigger to the shaper.
- attack_step_value  out  8  attack step of the selected preset.
- decay_step_value  out  8  decay step of the selected preset.
- sustain_level  out  8  sustain amplitude of the selected preset.
- release_step_value  out  8  release step of the selected preset.
- sustain_time  out  8  sustain duration of the selected preset.
- step_index  out  log2(NUM_STEPS)  step currently playing.
- missed_count  out  8  saturating count of skipped hits.

Behaviour:
- Reset values:
  - start=0, step_index=0, missed_count=0, all pattern entries 0.
  - ADSR outputs hold preset 0.
  - FSM in STOPPED.
  - Reset mid-run aborts immediately; no start pulse in the cycle after reset.
- Presets, fixed, as {attack, decay, sustain_level, release, sustain_time}:
  - 0 = {0x40, 0x08, 0x60, 0x04, 0x20}
  - 1 = {0xFF (bypass), 0x00, 0x00, 0x00, 0x00}
  - 2 = {0x80, 0x10, 0x40, 0x08, 0x10}
  - 3 = {0x10, 0x02, 0xA0, 0x01, 0x80}
- All outputs are registered.
- FSM states STOPPED, EVAL, COUNT:
  - STOPPED: step_index=0, timer=0. If run=1, go to EVAL next cycle.
  - EVAL (one cycle): read pattern[step_index] combinationally.
    - If hit=1 and (RETRIG=1 or adsr_idle=1): next cycle start=1 and the ADSR outputs load the preset, both in the same cycle.
    - If hit=1, RETRIG=0 and adsr_idle=0: start stays 0, missed_count increments (saturates at 0xFF), ADSR outputs hold.
    - Latch eff_period = max(step_period, 2). Go to COUNT with timer=1.
  - COUNT: timer increments each cycle.
    - When timer = eff_period-1: step_index <= step_index+1 (modulo NUM_STEPS) and go to EVAL.
    - Each step therefore occupies exactly eff_period cycles.
  - run=0 in any state: next cycle go to STOPPED, step_index=0, start=0; ADSR outputs hold their last values. A start pulse already registered completes its single cycle.
- Start timing: run rises at cycle T, so EVAL for step 0 is at T+1 and start is high at T+2. Step k start is at T+2+k*eff_period.
- Between hits, the ADSR outputs hold their last loaded values.
- Pattern writes occur whenever wr_en=1, in any state.
  - A write to the entry being read in EVAL in the same cycle: EVAL uses the old value; the new value applies on the next wrap.
- step_period changes mid-step take effect at the next EVAL only.

Test Plan:
- Reset, then run=0 for 20 cycles -> start=0 throughout, step_index=0, ADSR outputs = preset 0, missed_count=0.
- Write hit/preset2 at steps 0 and 4, step_period=8, run=1 at T -> start high only at T+2 and T+34, attack_step_value=0x80 from T+2, step_index wraps 15->0 at T+129.
- step_period=0 and 1 -> behaves as 2; a hit on every step gives start every 2 cycles.
- RETRIG=0, hits on steps 0 and 1, adsr_idle held 0 -> step 0 skipped, step 1 skipped, missed_count=2; adsr_idle=1 on the next wrap -> start fires for step 0.
- run dropped during COUNT of step 5 -> next cycle STOPPED, step_index=0; run re-raised -> step 0 start 2 cycles later.
- Write step 3 := {1,1} in the same cycle step 3 is in EVAL with old entry 0 -> no start this pass; next pass start fires with attack_step_value=0xFF.

Source files
------------

// File: rtl/drum_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : drum_step_sequencer
// Description : 16-step drum pattern sequencer that triggers the ADSR shaper
//               with a per-step preset at a programmable step period.
// Revision    : 1.0 - initial release
// ============================================================================
module drum_step_sequencer #(
  parameter int NUM_STEPS = 16,
  parameter int PERIOD_W  = 24,
  parameter bit RETRIG    = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         run,
  input  logic [PERIOD_W-1:0]          step_period,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_STEPS)-1:0] wr_addr,
  input  logic [2:0]                   wr_data,
  input  logic                         adsr_idle,
  output logic                         start,
  output logic [7:0]                   attack_step_value,
  output logic [7:0]                   decay_step_value,
  output logic [7:0]                   sustain_level,
  output logic [7:0]                   release_step_value,
  output logic [7:0]                   sustain_time,
  output logic [$clog2(NUM_STEPS)-1:0] step_index,
  output logic [7:0]                   missed_count
);

  localparam int IDX_W = $clog2(NUM_STEPS);

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_EVAL    = 2'd1,
    ST_COUNT   = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_pattern [NUM_STEPS];
  logic [PERIOD_W-1:0] r_timer, w_timer_nxt;
  logic [PERIOD_W-1:0] r_eff_period, w_eff_nxt;
  logic [IDX_W-1:0]    r_step_index, w_idx_nxt;
  logic                r_start, w_start_nxt;
  logic [39:0]         r_adsr, w_adsr_nxt;
  logic [7:0]          r_missed, w_missed_nxt;
  logic [2:0]          w_entry;

  // Preset packing: {attack, decay, sustain_level, release, sustain_time}
  function automatic logic [39:0] f_preset(input logic [1:0] sel);
    case (sel)
      2'd0:    f_preset = 40'h40_08_60_04_20;
      2'd1:    f_preset = 40'hFF_00_00_00_00;
      2'd2:    f_preset = 40'h80_10_40_08_10;
      default: f_preset = 40'h10_02_A0_01_80;
    endcase
  endfunction

  // Read before the write port updates, so a same-cycle write is seen next pass
  assign w_entry = r_pattern[r_step_index];

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_eff_nxt    = r_eff_period;
    w_idx_nxt    = r_step_index;
    w_start_nxt  = 1'b0;
    w_adsr_nxt   = r_adsr;
    w_missed_nxt = r_missed;
    if (!run) begin
      w_state_nxt = ST_STOPPED;
      w_timer_nxt = '0;
      w_idx_nxt   = '0;
    end else begin
      case (r_state)
        ST_STOPPED: begin
          w_state_nxt = ST_EVAL;
          w_timer_nxt = '0;
          w_idx_nxt   = '0;
        end
        ST_EVAL: begin
          if (w_entry[2]) begin
            if (RETRIG || adsr_idle) begin
              w_start_nxt = 1'b1;
              w_adsr_nxt  = f_preset(w_entry[1:0]);
            end else if (r_missed != 8'hFF) begin
              w_missed_nxt = r_missed + 8'd1;
            end
          end
          w_eff_nxt   = (step_period < PERIOD_W'(2)) ? PERIOD_W'(2) : step_period;
          w_timer_nxt = PERIOD_W'(1);
          w_state_nxt = ST_COUNT;
        end
        ST_COUNT: begin
          if (r_timer == r_eff_period - PERIOD_W'(1)) begin
            w_idx_nxt   = r_step_index + IDX_W'(1);
            w_timer_nxt = '0;
            w_state_nxt = ST_EVAL;
          end else begin
            w_timer_nxt = r_timer + PERIOD_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_STOPPED;
          w_timer_nxt = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_STOPPED;
      r_timer      <= '0;
      r_eff_period <= PERIOD_W'(2);
      r_step_index <= '0;
      r_start      <= 1'b0;
      r_adsr       <= f_preset(2'd0);
      r_missed     <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_eff_period <= w_eff_nxt;
      r_step_index <= w_idx_nxt;
      r_start      <= w_start_nxt;
      r_adsr       <= w_adsr_nxt;
      r_missed     <= w_missed_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_pattern[i] <= 3'd0;
      end
    end else if (wr_en) begin
      r_pattern[wr_addr] <= wr_data;
    end
  end

  assign start              = r_start;
  assign attack_step_value  = r_adsr[39:32];
  assign decay_step_value   = r_adsr[31:24];
  assign sustain_level      = r_adsr[23:16];
  assign release_step_value = r_adsr[15:8];
  assign sustain_time       = r_adsr[7:0];
  assign step_index         = r_step_index;
  assign missed_count       = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_drum_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_drum_step_sequencer
// Description : Self-checking bench for drum_step_sequencer (RETRIG=1 and 0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_drum_step_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, wr_en, adsr_idle;
  logic [23:0] step_period;
  logic [3:0]  wr_addr;
  logic [2:0]  wr_data;

  logic       r1_start, r0_start;
  logic [7:0] r1_att, r1_dec, r1_sus, r1_rel, r1_stm, r1_missed;
  logic [7:0] r0_att, r0_dec, r0_sus, r0_rel, r0_stm, r0_missed;
  logic [3:0] r1_step, r0_step;
  logic [39:0] adsr1, adsr0;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  assign adsr1 = {r1_att, r1_dec, r1_sus, r1_rel, r1_stm};
  assign adsr0 = {r0_att, r0_dec, r0_sus, r0_rel, r0_stm};

  drum_step_sequencer #(.NUM_STEPS(16), .PERIOD_W(24), .RETRIG(1'b1)) dut (
    .clk(clk), .reset(reset), .run(run), .step_period(step_period),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .adsr_idle(adsr_idle),
    .start(r1_start), .attack_step_value(r1_att), .decay_step_value(r1_dec),
    .sustain_level(r1_sus), .release_step_value(r1_rel), .sustain_time(r1_stm),
    .step_index(r1_step), .missed_count(r1_missed)
  );

  drum_step_sequencer #(.NUM_STEPS(16), .PERIOD_W(24), .RETRIG(1'b0)) dut0 (
    .clk(clk), .reset(reset), .run(run), .step_period(step_period),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .adsr_idle(adsr_idle),
    .start(r0_start), .attack_step_value(r0_att), .decay_step_value(r0_dec),
    .sustain_level(r0_sus), .release_step_value(r0_rel), .sustain_time(r0_stm),
    .step_index(r0_step), .missed_count(r0_missed)
  );

  typedef struct {
    int t;
    int k;
    int p;
  } sb_t;

  typedef struct {
    int          period;
    logic [15:0] mask;
    int          preset;
    int          ncyc;
  } vec_t;

  sb_t  exp_q[$];
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    nvec++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [39:0] preset_f(input int p);
    case (p)
      0:       preset_f = 40'h40_08_60_04_20;
      1:       preset_f = 40'hFF_00_00_00_00;
      2:       preset_f = 40'h80_10_40_08_10;
      default: preset_f = 40'h10_02_A0_01_80;
    endcase
  endfunction

  task automatic do_reset();
    reset       = 1'b1;
    run         = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = 4'd0;
    wr_data     = 3'd0;
    adsr_idle   = 1'b1;
    step_period = 24'd2;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = 4'(a);
    wr_data = 3'(d);
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask

  // Expected start cycles follow T+2+k*eff relative to the cycle run rises
  task automatic run_vec(input vec_t v);
    int  eff;
    sb_t e;
    eff = (v.period < 2) ? 2 : v.period;
    do_reset();
    for (int s = 0; s < 16; s++) begin
      if (v.mask[s]) wr(s, 4 | v.preset);
    end
    step_period = 24'(v.period);
    run         = 1'b1;
    for (int k = 0; 2 + k * eff <= v.ncyc; k++) begin
      if (v.mask[k % 16]) begin
        e.t = 2 + k * eff;
        e.k = k;
        e.p = v.preset;
        exp_q.push_back(e);
      end
    end
    for (int t = 1; t <= v.ncyc + 3; t++) begin
      @(posedge clk);
      #1;
      if (t == v.ncyc) run = 1'b0;
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].t == t) begin
        e = exp_q.pop_front();
        chk("start_pulse", 64'(r1_start), 64'd1);
        chk("start_adsr", 64'(adsr1), 64'(preset_f(e.p)));
        chk("start_step", 64'(r1_step), 64'(e.k % 16));
      end else if (r1_start) begin
        chk("spurious_start", 64'(r1_start), 64'd0);
      end
      if (t <= v.ncyc && (t - 1) % eff == 0)
        chk("eval_step", 64'(r1_step), 64'(((t - 1) / eff) % 16));
      if (t == v.ncyc + 2) begin
        chk("stop_step", 64'(r1_step), 64'd0);
        chk("stop_start", 64'(r1_start), 64'd0);
      end
    end
    if (exp_q.size() != 0) chk("sb_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{period: 8, mask: 16'h0011, preset: 2, ncyc: 140};
    vecs[1] = '{period: 0, mask: 16'hFFFF, preset: 3, ncyc: 40};
    vecs[2] = '{period: 1, mask: 16'hAAAA, preset: 1, ncyc: 40};
    vecs[3] = '{period: 5, mask: 16'h8001, preset: 0, ncyc: 100};

    // Reset state held while stopped
    do_reset();
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      chk("stopped_outputs", 64'({r1_start, r1_step, r1_missed, adsr1}),
          64'({1'b0, 4'd0, 8'd0, preset_f(0)}));
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Non-retriggerable voice skips hits while the shaper is busy
    do_reset();
    wr(0, 6);
    wr(1, 6);
    step_period = 24'd4;
    adsr_idle   = 1'b0;
    run         = 1'b1;
    for (int t = 1; t <= 66; t++) begin
      @(posedge clk);
      #1;
      if (t == 10) adsr_idle = 1'b1;
      @(negedge clk);
      if (t == 2) chk("retrig_fires_busy", 64'(r1_start), 64'd1);
      if (t < 66 && r0_start) chk("noretrig_skip", 64'(r0_start), 64'd0);
      if (t == 10) begin
        chk("missed_count", 64'(r0_missed), 64'd2);
        chk("skip_holds_adsr", 64'(adsr0), 64'(preset_f(0)));
        chk("retrig_no_miss", 64'(r1_missed), 64'd0);
      end
      if (t == 66) begin
        chk("wrap_fire", 64'(r0_start), 64'd1);
        chk("wrap_adsr", 64'(adsr0), 64'(preset_f(2)));
        chk("missed_hold", 64'(r0_missed), 64'd2);
      end
    end
    run = 1'b0;

    // Stop during step 5, then restart from step 0
    do_reset();
    for (int s = 0; s < 16; s++) wr(s, 7);
    step_period = 24'd4;
    run         = 1'b1;
    for (int t = 1; t <= 28; t++) begin
      @(posedge clk);
      #1;
      if (t == 22) run = 1'b0;
      if (t == 25) run = 1'b1;
      @(negedge clk);
      if (t == 22) begin
        chk("step5_start", 64'(r1_start), 64'd1);
        chk("step5_index", 64'(r1_step), 64'd5);
      end
      if (t == 23) begin
        chk("stop_index", 64'(r1_step), 64'd0);
        chk("stop_no_start", 64'(r1_start), 64'd0);
      end
      if (t == 26) chk("restart_eval", 64'(r1_start), 64'd0);
      if (t == 27) begin
        chk("restart_start", 64'(r1_start), 64'd1);
        chk("restart_index", 64'(r1_step), 64'd0);
        chk("restart_adsr", 64'(adsr1), 64'(preset_f(3)));
      end
    end
    run = 1'b0;

    // Write to the entry under evaluation applies on the next pass
    do_reset();
    step_period = 24'd4;
    run         = 1'b1;
    for (int t = 1; t <= 78; t++) begin
      @(posedge clk);
      #1;
      if (t == 13) begin
        wr_en   = 1'b1;
        wr_addr = 4'd3;
        wr_data = 3'b101;
      end else begin
        wr_en = 1'b0;
      end
      @(negedge clk);
      if (t == 14) chk("old_entry_used", 64'(r1_start), 64'd0);
      else if (t < 78 && r1_start) chk("no_start_first_pass", 64'(r1_start), 64'd0);
      if (t == 78) begin
        chk("new_entry_start", 64'(r1_start), 64'd1);
        chk("new_entry_adsr", 64'(adsr1), 64'(preset_f(1)));
        chk("new_entry_index", 64'(r1_step), 64'd3);
      end
    end
    run = 1'b0;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
